// File: rtl/mem_bus_initiator_if.sv
// Native memory bus bundle shared between a bus master and its responder.
//
// Signals:
//   mem_valid  master -> slave  request pending
//   mem_instr  master -> slave  instruction fetch flag
//   mem_addr   master -> slave  byte address
//   mem_wdata  master -> slave  write data
//   mem_wstrb  master -> slave  byte enables, 4'b0000 for a read
//   mem_ready  slave -> master  request completes on this edge
//   mem_rdata  slave -> master  read data, valid while mem_ready=1
//
// Modports: master (initiator side), slave (responder side).

interface mem_bus_initiator_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_instr,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_instr,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/mem_bus_initiator.sv
// Command-driven initiator on the native memory bus.
//
// Read/write commands arrive on a valid/ready channel and are buffered in a small FIFO.
// They are issued one at a time on the memory bus in arrival order, and each produces
// exactly one response on a valid/ready response channel.
//
// Optional feature (macro MEM_BUS_INITIATOR_TIMEOUT_EN): a bus request left without
// mem_ready for TIMEOUT_CYCLES cycles is abandoned and answered with rsp_err=1.
// Without the macro the initiator waits indefinitely and rsp_err is constant 0.
//
// Parameters:
//   CMD_DEPTH       command FIFO entries (power of 2, >= 2)
//   TIMEOUT_CYCLES  bus wait limit, used only with the timeout feature
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   cmd_valid  command offered
//   cmd_ready  command FIFO can accept
//   cmd_addr   command byte address
//   cmd_wdata  command write data
//   cmd_wstrb  command byte enables, 4'b0000 means read
//   rsp_valid  response available
//   rsp_ready  response consumed
//   rsp_rdata  read data, 0 for writes
//   rsp_err    transaction timed out
//   busy       FIFO non-empty or a transaction in progress
//   bus        memory bus, master side

module mem_bus_initiator #(
  parameter int unsigned CMD_DEPTH      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,

  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [31:0]                cmd_addr,
  input  logic [31:0]                cmd_wdata,
  input  logic [3:0]                 cmd_wstrb,

  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [31:0]                rsp_rdata,
  output logic                       rsp_err,

  output logic                       busy,

  mem_bus_initiator_if.master        bus
);

  localparam int unsigned PtrW = $clog2(CMD_DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } state_e;

  // ---------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases on a clock edge so that every flop
  // below leaves reset in the same cycle.
  // ---------------------------------------------------------------------------
  logic rst_meta_q;
  logic rst_sync_q;
  logic rst_int_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign rst_int_n = rst_sync_q;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t            fifo_q [CMD_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic [PtrW:0]   count_d;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  cmd_t            head;

  assign fifo_full  = (count_q == (PtrW + 1)'(CMD_DEPTH));
  assign fifo_empty = (count_q == '0);
  // Held low until the internal reset has released so no command is dropped.
  assign cmd_ready  = !fifo_full && rst_sync_q;
  assign push       = cmd_valid && cmd_ready;
  assign head       = fifo_q[rd_ptr_q];

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{addr: cmd_addr, wdata: cmd_wdata, wstrb: cmd_wstrb};
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (PtrW + 1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM and registered bus/response outputs
  // ---------------------------------------------------------------------------
  state_e      state_q;
  state_e      state_d;
  logic        mem_valid_q;
  logic        mem_valid_d;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_addr_d;
  logic [31:0] mem_wdata_q;
  logic [31:0] mem_wdata_d;
  logic [3:0]  mem_wstrb_q;
  logic [3:0]  mem_wstrb_d;
  logic        rsp_valid_q;
  logic        rsp_valid_d;
  logic [31:0] rsp_rdata_q;
  logic [31:0] rsp_rdata_d;

`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_cnt_q;
  logic [TmoW-1:0] tmo_cnt_d;
  logic            tmo_hit;
  logic            rsp_err_q;
  logic            rsp_err_d;

  // The edge that would take the wait count to TIMEOUT_CYCLES is the timeout edge.
  assign tmo_hit = (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (pop) begin
      tmo_cnt_d = '0;
    end else if (state_q == StIssue && !bus.mem_ready) begin
      tmo_cnt_d = tmo_cnt_q + TmoW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      tmo_cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end

      StIssue: begin
        // A ready on the timeout edge still completes normally.
        if (bus.mem_ready) begin
          mem_valid_d = 1'b0;
          rsp_rdata_d = (mem_wstrb_q == 4'b0000) ? bus.mem_rdata : 32'h0;
          rsp_valid_d = 1'b1;
`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = StResp;
        end
`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
        else if (tmo_hit) begin
          mem_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
`endif
      end

      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = StIssue;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Loading the bus registers from the FIFO head is common to both pop sites.
    if (pop) begin
      mem_valid_d = 1'b1;
      mem_addr_d  = head.addr;
      mem_wdata_d = head.wdata;
      mem_wstrb_d = head.wstrb;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= StIdle;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_instr = 1'b0;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  assign busy = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Testbench for mem_bus_initiator: directed scenarios with literal expectations plus a
// randomized phase, all continuously compared against a queue-based reference model.

module tb_mem_bus_initiator;

  localparam int unsigned CmdDepth  = 2;
  localparam int unsigned TmoCycles = 16;
  localparam logic [31:0] RdKey     = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  // Responder controls
  logic        mem_ready_drv;
  logic        rdata_from_addr;
  logic [31:0] rdata_drv;

  int n_checks;
  int n_errors;

  mem_bus_initiator_if bus_if ();

  assign bus_if.mem_ready = mem_ready_drv;
  assign bus_if.mem_rdata = rdata_from_addr ? (bus_if.mem_addr ^ RdKey) : rdata_drv;

  mem_bus_initiator #(
    .CMD_DEPTH      (CmdDepth),
    .TIMEOUT_CYCLES (TmoCycles)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: a command queue, one transaction slot that is either on the
  // bus or waiting as a response, and a count of edges since reset release.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  cmd_t        m_fifo[$];
  cmd_t        m_cur;
  bit          m_bus;
  bit          m_rsp;
  logic [31:0] m_rdata;
  bit          m_err;
  int          m_wait;
  int          m_rdy_cnt;

  function automatic logic [31:0] resp_data(input logic [31:0] addr);
    return rdata_from_addr ? (addr ^ RdKey) : rdata_drv;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit can_push;
    bit take;
    if (!reset_n) begin
      m_fifo.delete();
      m_bus     = 0;
      m_rsp     = 0;
      m_wait    = 0;
      m_rdy_cnt = 0;
      return;
    end
    // Two edges after reset release before commands are taken.
    if (m_rdy_cnt < 2) begin
      m_rdy_cnt++;
      return;
    end
    can_push = cmd_valid && (m_fifo.size() < int'(CmdDepth));
    take     = 0;
    if (m_bus) begin
      if (bus_if.mem_ready) begin
        m_bus   = 0;
        m_rsp   = 1;
        m_rdata = (m_cur.wstrb == 4'h0) ? resp_data(m_cur.addr) : 32'h0;
        m_err   = 0;
      end else begin
        m_wait++;
`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
        if (m_wait == int'(TmoCycles)) begin
          m_bus   = 0;
          m_rsp   = 1;
          m_rdata = 32'h0;
          m_err   = 1;
        end
`endif
      end
    end else if (m_rsp) begin
      if (rsp_ready) begin
        m_rsp = 0;
        take  = (m_fifo.size() > 0);
      end
    end else begin
      take = (m_fifo.size() > 0);
    end
    if (take) begin
      m_cur  = m_fifo.pop_front();
      m_bus  = 1;
      m_wait = 0;
    end
    if (can_push) m_fifo.push_back('{cmd_addr, cmd_wdata, cmd_wstrb});
  endtask

  task automatic check_step();
    if (!reset_n) return;
    chk("cmd_ready", {31'h0, cmd_ready}, {31'h0, (m_rdy_cnt == 2 && m_fifo.size() < int'(CmdDepth))});
    chk("mem_valid", {31'h0, bus_if.mem_valid}, {31'h0, m_bus});
    chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, m_rsp});
    chk("busy", {31'h0, busy}, {31'h0, (m_fifo.size() != 0 || m_bus || m_rsp)});
    chk("mem_instr", {31'h0, bus_if.mem_instr}, 32'h0);
    if (m_bus) begin
      chk("mem_addr", bus_if.mem_addr, m_cur.addr);
      chk("mem_wdata", bus_if.mem_wdata, m_cur.wdata);
      chk("mem_wstrb", {28'h0, bus_if.mem_wstrb}, {28'h0, m_cur.wstrb});
    end
    if (m_rsp) begin
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", {31'h0, rsp_err}, {31'h0, m_err});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (driver always sits just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wstrb = wstrb;
    for (int i = 0; i < 2000 && !cmd_ready; i++) cyc();
    chk("push_wait", {31'h0, cmd_ready}, 32'h1);
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic rsp_take();
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
  endtask

  logic [31:0] bp_exp [4];
  int          cnt;
  int          got;
  bit          d_acc;

  initial begin
    reset_n         = 1'b0;
    cmd_valid       = 1'b0;
    cmd_addr        = '0;
    cmd_wdata       = '0;
    cmd_wstrb       = '0;
    rsp_ready       = 1'b0;
    mem_ready_drv   = 1'b0;
    rdata_from_addr = 1'b0;
    rdata_drv       = '0;
    n_checks        = 0;
    n_errors        = 0;

    fork
      forever begin
        @(posedge clk);
        model_step();
      end
      forever begin
        @(negedge clk);
        check_step();
      end
    join_none

    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    chk("rst_mem_valid", {31'h0, bus_if.mem_valid}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_addr", bus_if.mem_addr, 32'h0);
    chk("rst_cmd_ready_low", {31'h0, cmd_ready}, 32'h0);
    cyc();
    cyc();
    chk("rst_cmd_ready_high", {31'h0, cmd_ready}, 32'h1);

    // Write, zero wait states
    mem_ready_drv = 1'b1;
    push(32'hF000_1000, 32'h0000_002A, 4'hF);
    chk("wr_e0_mem_valid", {31'h0, bus_if.mem_valid}, 32'h0);
    cyc();
    chk("wr_e1_mem_valid", {31'h0, bus_if.mem_valid}, 32'h1);
    chk("wr_e1_addr", bus_if.mem_addr, 32'hF000_1000);
    chk("wr_e1_wdata", bus_if.mem_wdata, 32'h0000_002A);
    chk("wr_e1_wstrb", {28'h0, bus_if.mem_wstrb}, 32'hF);
    cyc();
    chk("wr_e2_mem_valid", {31'h0, bus_if.mem_valid}, 32'h0);
    chk("wr_e2_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("wr_e2_rsp_rdata", rsp_rdata, 32'h0);
    chk("wr_e2_rsp_err", {31'h0, rsp_err}, 32'h0);
    rsp_take();
    chk("wr_rsp_cleared", {31'h0, rsp_valid}, 32'h0);

    // Read with three wait states
    mem_ready_drv = 1'b0;
    push(32'h0000_0100, 32'h0, 4'h0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("rd_wait_valid", {31'h0, bus_if.mem_valid}, 32'h1);
      chk("rd_wait_addr", bus_if.mem_addr, 32'h0000_0100);
      if (i == 3) begin
        mem_ready_drv = 1'b1;
        rdata_drv     = 32'h1234_5678;
      end
      cyc();
    end
    chk("rd_done_valid", {31'h0, bus_if.mem_valid}, 32'h0);
    chk("rd_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    rsp_take();

    // Backpressure and simultaneous push/pop with one queued entry
    rdata_from_addr = 1'b1;
    bp_exp[0] = 32'h10 ^ RdKey;
    bp_exp[1] = 32'h20 ^ RdKey;
    bp_exp[2] = 32'h30 ^ RdKey;
    bp_exp[3] = 32'h40 ^ RdKey;
    push(32'h10, 32'h0, 4'h0);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h20;
    chk("pp_ready", {31'h0, cmd_ready}, 32'h1);
    cyc();
    chk("pp_issue_addr", bus_if.mem_addr, 32'h10);
    chk("pp_occ_one", {31'h0, cmd_ready}, 32'h1);
    cmd_addr = 32'h30;
    cyc();
    cmd_addr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      chk("bp_full", {31'h0, cmd_ready}, 32'h0);
      chk("bp_hold_valid", {31'h0, rsp_valid}, 32'h1);
      chk("bp_hold_rdata", rsp_rdata, bp_exp[0]);
      cyc();
    end
    rsp_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && got < 4; i++) begin
      d_acc = cmd_valid && cmd_ready;
      if (rsp_valid) begin
        chk($sformatf("bp_rsp%0d", got), rsp_rdata, bp_exp[got]);
        got++;
      end
      cyc();
      if (d_acc) cmd_valid = 1'b0;
    end
    chk("bp_count", got, 32'd4);
    rsp_ready       = 1'b0;
    rdata_from_addr = 1'b0;

    // Stuck responder
    mem_ready_drv = 1'b0;
    push(32'h0000_0200, 32'hDEAD_BEEF, 4'h3);
    cyc();
    chk("stuck_wstrb", {28'h0, bus_if.mem_wstrb}, 32'h3);
`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
    cnt = 0;
    for (int i = 0; i < 100 && bus_if.mem_valid; i++) begin
      cnt++;
      cyc();
    end
    chk("tmo_cycles", cnt, TmoCycles);
    chk("tmo_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("tmo_rsp_err", {31'h0, rsp_err}, 32'h1);
    chk("tmo_rsp_rdata", rsp_rdata, 32'h0);
    rsp_take();
`else
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus_if.mem_valid) cnt++;
      cyc();
    end
    chk("notmo_cycles", cnt, 32'd1000);
    mem_ready_drv = 1'b1;
    cyc();
    chk("notmo_rsp_err", {31'h0, rsp_err}, 32'h0);
    rsp_take();
`endif
    mem_ready_drv = 1'b1;
    rdata_drv     = 32'hCAFE_F00D;
    push(32'h0000_0300, 32'h0, 4'h0);
    cyc();
    cyc();
    chk("after_stuck_valid", {31'h0, rsp_valid}, 32'h1);
    chk("after_stuck_err", {31'h0, rsp_err}, 32'h0);
    chk("after_stuck_rdata", rsp_rdata, 32'hCAFE_F00D);
    rsp_take();

    // Reset while a request is on the bus
    mem_ready_drv = 1'b0;
    push(32'h0000_0400, 32'h0, 4'h0);
    cyc();
    chk("rst_mid_pre", {31'h0, bus_if.mem_valid}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_mem_valid", {31'h0, bus_if.mem_valid}, 32'h0);
    chk("rst_mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("rst_mid_empty", {31'h0, busy}, 32'h0);
    mem_ready_drv = 1'b1;
    push(32'hF000_1004, 32'h0000_0055, 4'hF);
    cyc();
    chk("rst_mid_wr_addr", bus_if.mem_addr, 32'hF000_1004);
    cyc();
    chk("rst_mid_wr_rsp", {31'h0, rsp_valid}, 32'h1);
    chk("rst_mid_wr_rdata", rsp_rdata, 32'h0);
    rsp_take();

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      case ($urandom_range(0, 2))
        0:       cmd_wstrb = 4'h0;
        1:       cmd_wstrb = 4'hF;
        default: cmd_wstrb = 4'($urandom_range(0, 15));
      endcase
      rsp_ready     = ($urandom_range(0, 3) != 0);
      mem_ready_drv = ($urandom_range(0, 2) == 0);
      rdata_drv     = $urandom;
      cyc();
    end

    // Drain
    cmd_valid     = 1'b0;
    rsp_ready     = 1'b1;
    mem_ready_drv = 1'b1;
    for (int i = 0; i < 50 && busy; i++) cyc();
    chk("drain_busy", {31'h0, busy}, 32'h0);
    chk("drain_rsp_valid", {31'h0, rsp_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_initiator.md
Name: mem_bus_initiator

Overview:
- Command-driven initiator on the native memory bus (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata) used by the CPU and the memory-mapped peripherals.
- Accepts read/write commands on a valid/ready command channel, buffers them, and issues them one at a time as bus transactions. Returns one response per command on a valid/ready response channel.
- Sits beside the CPU as a second bus master (debug loader, DMA front end) ahead of the address decoder/arbiter.

Parameters:
- CMD_DEPTH, 2, command FIFO entries; power of 2, >= 2.
- TIMEOUT_CYCLES, 1024, cycles mem_valid may stay high without mem_ready before the bus error path fires (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  byte enables; 4'b0000 means read.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_err  out  1  transaction timed out.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- mem_valid  out  1  bus request.
- mem_instr  out  1  tied 0.
- mem_ready  in  1  responder ready; may be combinational or constant 1.
- mem_addr  out  32  request address.
- mem_wdata  out  32  request write data.
- mem_wstrb  out  4  request byte enables.
- mem_rdata  in  32  responder read data, valid when mem_ready=1.

Behaviour:
- Reset (async assert, sync deassert inside): FIFO emptied, FSM=IDLE, all outputs 0 (cmd_ready becomes 1 after reset). Commands in flight are discarded. mem_valid drops immediately.
- Command push: on an edge with cmd_valid && cmd_ready. cmd_ready = !full.
- Response channel: rsp_valid, once set, stays set until the rsp_ready edge. Payload is held stable while rsp_valid=1.
- Bus outputs: all registered. mem_addr/mem_wdata/mem_wstrb are stable whenever mem_valid=1.
- FSM:
  - IDLE: if FIFO non-empty, pop the head into the mem_* registers and set mem_valid, then go to ISSUE.
  - ISSUE: mem_valid=1. On an edge with mem_ready=1:
    - Clear mem_valid.
    - Latch rsp_rdata: mem_rdata if mem_wstrb==0, else 0.
    - Set rsp_err=0 and rsp_valid=1, then go to RESP.
  - RESP: on rsp_ready=1, clear rsp_valid. If FIFO non-empty, pop and go to ISSUE (mem_valid set that edge); else go to IDLE.
- Ordering and concurrency: one outstanding bus transaction. Strict FIFO order. Responses never reorder or drop.
- Latency with constant mem_ready=1 and rsp_ready=1:
  - Command edge E0 into empty IDLE.
  - mem_valid high after E1.
  - Completes at E2; rsp_valid high after E2.
  - Back-to-back throughput is 1 command per 2 cycles.
- Simultaneous push and pop in the same edge is legal. Occupancy is unchanged.
- Address and strobes pass through unmodified; no alignment checks.
- mem_wstrb values other than 0000/1111 pass through unchanged.

Optional Feature:
- Macro: MEM_BUS_INITIATOR_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to ISSUE and increments each ISSUE cycle while mem_ready=0.
  - When it reaches TIMEOUT_CYCLES, the FSM clears mem_valid, sets rsp_rdata=0, rsp_err=1, rsp_valid=1, and goes to RESP.
  - mem_ready arriving on the same edge as the timeout wins (normal completion, err=0).
- Without the macro: no counter; ISSUE waits indefinitely; rsp_err is constant 0.

Test Plan:
- Write: cmd addr=0xF000_1000, wdata=0x0000_002A, wstrb=4'hF, mem_ready=1 -> mem_valid high exactly 1 cycle with those values. rsp_valid next cycle, rsp_rdata=0, rsp_err=0.
- Read with wait states: cmd addr=0x0000_0100, wstrb=0. mem_ready raised after 3 low cycles with mem_rdata=0x1234_5678 -> mem_valid high 4 cycles with address stable. rsp_rdata=0x1234_5678.
- Backpressure: rsp_ready=0, issue 4 commands with CMD_DEPTH=2, mem_ready=1 -> first completes and sits in RESP, next 2 fill the FIFO, cmd_ready=0 for the 4th. Raise rsp_ready -> 3 responses emerge in order, then the 4th is accepted.
- Timeout (macro on, TIMEOUT_CYCLES=16): mem_ready held 0 -> mem_valid falls after 16 cycles, rsp_err=1, rsp_rdata=0. The next command completes normally. With the macro off, mem_valid stays high for 1000 cycles.
- Reset mid-ISSUE: assert reset_n=0 while mem_valid=1 -> mem_valid, rsp_valid and busy go 0 without waiting for a clock edge. After release, FIFO is empty and a new write completes normally.
- Push/pop same edge with FIFO at 1 entry -> occupancy stays 1, no command lost, order preserved.
